// File: rtl/nn_ctrl_pkg.sv
// Shared definitions for the inference controller and the display path:
// state codes, the blank-digit value and the layer index width.
package nn_ctrl_pkg;

  localparam int STATE_W = 4;
  localparam int LAYER_W = 2;

  localparam logic [3:0] ST_IDLE        = 4'd0;
  localparam logic [3:0] ST_LAYER_START = 4'd1;
  localparam logic [3:0] ST_LAYER_WAIT  = 4'd2;
  localparam logic [3:0] ST_AM_START    = 4'd3;
  localparam logic [3:0] ST_AM_WAIT     = 4'd4;
  localparam logic [3:0] ST_DONE        = 4'd5;
  localparam logic [3:0] ST_ERROR       = 4'd6;

  // Value shown as an empty digit on the 7-segment display.
  localparam logic [3:0] BLANK_DIGIT = 4'd10;

  // A run is in progress in every state except the three resting states.
  function automatic logic is_busy(input logic [3:0] st);
    return !((st == ST_IDLE) || (st == ST_DONE) || (st == ST_ERROR));
  endfunction

  // States where a new start edge is accepted.
  function automatic logic is_resting(input logic [3:0] st);
    return (st == ST_IDLE) || (st == ST_DONE) || (st == ST_ERROR);
  endfunction

  // States that wait for a done pulse under the watchdog.
  function automatic logic is_wait(input logic [3:0] st);
    return (st == ST_LAYER_WAIT) || (st == ST_AM_WAIT);
  endfunction

endpackage

// File: rtl/nn_watchdog.sv
// Cycle counter guarding a handshake wait. It is cleared on the cycle before
// a wait state is entered, counts while enabled, and flags the last allowed
// cycle so the controller can leave for ERROR if no done pulse shows up.
module nn_watchdog #(
  parameter int LIMIT = 4096
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CNT_W-1:0] count_reg;

  // Count cycles spent in the wait state; restart on each new wait.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  // High only on the final cycle of the allowed window.
  always_comb begin
    expired = enable && (count_reg == CNT_W'(LIMIT - 1));
  end

endmodule

// File: rtl/nn_inference_sequencer.sv
// Top-level inference controller: turns a start edge into per-layer
// matrix-multiply handshakes followed by one argmax handshake, latches the
// class for display and reports state for LED debug. A watchdog aborts any
// wait that never sees its done pulse.
module nn_inference_sequencer
  import nn_ctrl_pkg::*;
#(
  parameter int NUM_LAYERS     = 3,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  output logic         mm_start,
  output logic [1:0]   mm_layer,
  output logic         relu_en,
  input  logic         mm_done,
  output logic         am_start,
  input  logic         am_done,
  input  logic [3:0]   am_result,
  output logic         busy,
  output logic         done,
  output logic         timeout,
  output logic [3:0]   result,
  output logic [3:0]   current_state
);

  localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);

  logic                 start_q;
  logic                 go;
  logic [3:0]           state_reg;
  logic [3:0]           state_next;
  logic [LAYER_W-1:0]   layer_reg;
  logic [LAYER_W-1:0]   layer_next;
  logic [3:0]           result_reg;
  logic [3:0]           result_next;
  logic                 mm_start_reg;
  logic                 am_start_reg;
  logic                 busy_reg;
  logic                 done_reg;
  logic                 timeout_reg;
  logic                 wd_clear;
  logic                 wd_enable;
  logic                 wd_expired;

  assign go = start & ~start_q;

  // Watchdog restarts whenever a start state hands over to its wait state.
  assign wd_clear  = (state_reg == ST_LAYER_START) || (state_reg == ST_AM_START);
  assign wd_enable = is_wait(state_reg);

  nn_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .resetn  (resetn),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  // Next-state, layer index and result selection for the sequencer.
  always_comb begin
    state_next  = state_reg;
    layer_next  = layer_reg;
    result_next = result_reg;
    case (state_reg)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (go) begin
          state_next  = ST_LAYER_START;
          layer_next  = '0;
          result_next = BLANK_DIGIT;
        end
      end
      ST_LAYER_START: begin
        state_next = ST_LAYER_WAIT;
      end
      ST_LAYER_WAIT: begin
        // A done pulse on the expiry cycle still counts as success.
        if (mm_done) begin
          if (layer_reg == LAST_LAYER) begin
            state_next = ST_AM_START;
          end else begin
            layer_next = layer_reg + LAYER_W'(1);
            state_next = ST_LAYER_START;
          end
        end else if (wd_expired) begin
          state_next = ST_ERROR;
        end
      end
      ST_AM_START: begin
        state_next = ST_AM_WAIT;
      end
      ST_AM_WAIT: begin
        if (am_done) begin
          result_next = am_result;
          state_next  = ST_DONE;
        end else if (wd_expired) begin
          state_next = ST_ERROR;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
    // The layer index only has meaning during a run.
    if (is_resting(state_next)) begin
      layer_next = '0;
    end
  end

  // State, edge-detect history and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      start_q      <= 1'b0;
      state_reg    <= ST_IDLE;
      layer_reg    <= '0;
      result_reg   <= BLANK_DIGIT;
      mm_start_reg <= 1'b0;
      am_start_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      timeout_reg  <= 1'b0;
    end else begin
      start_q      <= start;
      state_reg    <= state_next;
      layer_reg    <= layer_next;
      result_reg   <= result_next;
      mm_start_reg <= (state_next == ST_LAYER_START);
      am_start_reg <= (state_next == ST_AM_START);
      busy_reg     <= is_busy(state_next);
      done_reg     <= (state_next == ST_DONE);
      timeout_reg  <= (state_next == ST_ERROR);
    end
  end

  assign mm_start      = mm_start_reg;
  assign am_start      = am_start_reg;
  assign mm_layer      = layer_reg;
  assign relu_en       = (layer_reg < LAST_LAYER);
  assign busy          = busy_reg;
  assign done          = done_reg;
  assign timeout       = timeout_reg;
  assign result        = result_reg;
  assign current_state = state_reg;

endmodule

// File: tb/tb_nn_inference_sequencer.sv
// Scoreboard bench for nn_inference_sequencer. Each run's expected output
// events (layer launches, argmax launch, completion or abort, with the cycle
// each should appear) are computed from the handshake rules and queued; a
// monitor pops and compares whenever the DUT shows an event.
module tb_nn_inference_sequencer;

  localparam int NL = 3;
  localparam int TO = 16;

  localparam int EV_MM   = 0;
  localparam int EV_AM   = 1;
  localparam int EV_DONE = 2;
  localparam int EV_ERR  = 3;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic       mm_done = 1'b0;
  logic       am_done = 1'b0;
  logic [3:0] am_result = 4'd0;
  logic       mm_start;
  logic [1:0] mm_layer;
  logic       relu_en;
  logic       am_start;
  logic       busy;
  logic       done;
  logic       timeout;
  logic [3:0] result;
  logic [3:0] current_state;

  nn_inference_sequencer #(
    .NUM_LAYERS     (NL),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .start         (start),
    .mm_start      (mm_start),
    .mm_layer      (mm_layer),
    .relu_en       (relu_en),
    .mm_done       (mm_done),
    .am_start      (am_start),
    .am_done       (am_done),
    .am_result     (am_result),
    .busy          (busy),
    .done          (done),
    .timeout       (timeout),
    .result        (result),
    .current_state (current_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int kind;
    int layer;
    int res;
    int cyc;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  // Responder configuration for the current run.
  int cfg_d[NL];
  int cfg_am_d = 1;
  int cfg_drop = -1;
  int cfg_am   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic pop_ev(input string name, output ev_t e, output bit got);
    n_cmp++;
    got = (exp_q.size() != 0);
    if (!got) begin
      n_bad++;
      $display("FAIL %s: got an output event with none expected (cycle %0d)", name, cyc);
      e = '{default: 0};
    end else begin
      e = exp_q.pop_front();
    end
  endtask

  // Monitor: compare every visible output event against the queue head.
  initial begin : monitor
    ev_t e;
    bit  got;
    logic pd;
    logic pt;
    pd = 1'b0;
    pt = 1'b0;
    forever begin
      @(negedge clk);
      if (mm_start) begin
        pop_ev("mm_start_event", e, got);
        if (got) begin
          chk("mm_event_kind", EV_MM, e.kind);
          chk("mm_layer", int'(mm_layer), e.layer);
          chk("relu_en", int'(relu_en), (e.layer < NL - 1) ? 1 : 0);
          chk("mm_start_cycle", cyc, e.cyc);
          chk("busy_in_layer", int'(busy), 1);
        end
      end
      if (am_start) begin
        pop_ev("am_start_event", e, got);
        if (got) begin
          chk("am_event_kind", EV_AM, e.kind);
          chk("am_start_cycle", cyc, e.cyc);
        end
      end
      if (done && !pd) begin
        pop_ev("done_event", e, got);
        if (got) begin
          chk("done_event_kind", EV_DONE, e.kind);
          chk("result", int'(result), e.res);
          chk("done_state", int'(current_state), 5);
          chk("done_cycle", cyc, e.cyc);
          chk("done_layer_zero", int'(mm_layer), 0);
          chk("done_not_busy", int'(busy), 0);
          chk("done_no_timeout", int'(timeout), 0);
        end
      end
      if (timeout && !pt) begin
        pop_ev("timeout_event", e, got);
        if (got) begin
          chk("err_event_kind", EV_ERR, e.kind);
          chk("err_result_blank", int'(result), 10);
          chk("err_state", int'(current_state), 6);
          chk("err_cycle", cyc, e.cyc);
          chk("err_done_low", int'(done), 0);
        end
      end
      pd = done;
      pt = timeout;
    end
  end

  // Matrix-multiply unit model: answer each launch after the configured delay.
  initial begin : mm_responder
    int l;
    forever begin
      @(negedge clk);
      if (mm_start) begin
        l = int'(mm_layer);
        if (l != cfg_drop) begin
          repeat (cfg_d[l]) @(posedge clk);
          #1 mm_done = 1'b1;
          @(posedge clk);
          #1 mm_done = 1'b0;
        end
      end
    end
  end

  // Argmax unit model; am_result carries junk outside the done pulse.
  initial begin : am_responder
    forever begin
      @(negedge clk);
      if (am_start) begin
        repeat (cfg_am_d) @(posedge clk);
        #1 am_done = 1'b1;
        am_result = 4'(cfg_am);
        @(posedge clk);
        #1 am_done = 1'b0;
        am_result = 4'($urandom_range(0, 15));
      end
    end
  end

  // Produce a clean start rising edge; returns the cycle in which it is seen.
  task automatic start_edge(output int t);
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1 start = 1'b1;
    t = cyc;
  endtask

  // One full run: choose delays, queue the expected events, launch, wait.
  task automatic run(input int am_res, input int drop, input int fixed_d);
    int t;
    int s;
    bit fin;
    for (int l = 0; l < NL; l++) cfg_d[l] = (fixed_d > 0) ? fixed_d : int'($urandom_range(1, TO));
    cfg_am_d = (fixed_d > 0) ? fixed_d : int'($urandom_range(1, TO));
    cfg_drop = drop;
    cfg_am   = am_res;
    start_edge(t);
    // Each layer occupies its start cycle plus the wait until done.
    s = t + 1;
    for (int l = 0; l < NL; l++) begin
      exp_q.push_back('{EV_MM, l, 0, s});
      if (l == drop) begin
        exp_q.push_back('{EV_ERR, l, 10, s + 1 + TO});
        break;
      end
      s = s + 1 + cfg_d[l];
    end
    if (drop < 0) begin
      exp_q.push_back('{EV_AM, 0, 0, s});
      exp_q.push_back('{EV_DONE, 0, am_res, s + 1 + cfg_am_d});
    end
    $display("run: am_result=%0d drop_layer=%0d delays=%0d/%0d/%0d am_delay=%0d start_cycle=%0d",
             am_res, drop, cfg_d[0], cfg_d[1], cfg_d[2], cfg_am_d, t);
    @(negedge clk);
    @(negedge clk);
    chk("run_entry_state", int'(current_state), 1);
    chk("run_entry_result_blank", int'(result), 10);
    chk("run_entry_timeout_clear", int'(timeout), 0);
    chk("run_entry_done_low", int'(done), 0);
    fin = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done || timeout) begin
        fin = 1'b1;
        break;
      end
    end
    chk("run_finished", int'(fin), 1);
    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_state"}, int'(current_state), 0);
    chk({tag, "_mm_start"}, int'(mm_start), 0);
    chk({tag, "_am_start"}, int'(am_start), 0);
    chk({tag, "_mm_layer"}, int'(mm_layer), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_timeout"}, int'(timeout), 0);
    chk({tag, "_result"}, int'(result), 10);
  endtask

  initial begin : global_guard
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "bench time limit");
  end

  initial begin : stimulus
    int t;
    int am_res;
    int drop;
    for (int l = 0; l < NL; l++) cfg_d[l] = 1;

    // Reset state.
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset_values("reset");
    resetn = 1'b1;
    $display("reset: outputs checked");

    // Stray done pulses in IDLE are ignored.
    @(posedge clk);
    #1 mm_done = 1'b1;
    am_done = 1'b1;
    am_result = 4'd3;
    @(posedge clk);
    #1 mm_done = 1'b0;
    am_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("stray_state_idle", int'(current_state), 0);
    chk("stray_result_blank", int'(result), 10);
    chk("stray_not_busy", int'(busy), 0);
    $display("stray: done pulses in IDLE");

    // Normal run, done pulses five cycles after each start.
    run(7, -1, 5);
    chk("normal_result", int'(result), 7);
    chk("normal_state", int'(current_state), 5);

    // Minimum latency run.
    run(int'($urandom_range(0, 9)), -1, 1);

    // Start held high: no rerun.
    repeat (20) @(negedge clk);
    chk("held_start_state", int'(current_state), 5);
    chk("held_start_no_events", exp_q.size(), 0);
    $display("held: start high for 20 cycles after run");

    // Low-then-high start gives a new run.
    run(int'($urandom_range(0, 9)), -1, 0);

    // mm_done never arrives for layer 1, then a clean recovery run.
    run(2, 1, 0);
    chk("abort_timeout_level", int'(timeout), 1);
    chk("abort_result_blank", int'(result), 10);
    run(int'($urandom_range(0, 9)), -1, 0);

    // Done pulses exactly on the watchdog's last cycle.
    run(4, -1, TO);
    chk("expiry_result", int'(result), 4);

    // Asynchronous reset during AM_WAIT.
    for (int l = 0; l < NL; l++) cfg_d[l] = 1;
    cfg_am_d = 12;
    cfg_drop = -1;
    cfg_am   = 5;
    start_edge(t);
    exp_q.push_back('{EV_MM, 0, 0, t + 1});
    exp_q.push_back('{EV_MM, 1, 0, t + 3});
    exp_q.push_back('{EV_MM, 2, 0, t + 5});
    exp_q.push_back('{EV_AM, 0, 0, t + 7});
    for (int i = 0; i < 100 && current_state != 4'd4; i++) @(negedge clk);
    chk("reached_am_wait", int'(current_state), 4);
    #2 resetn = 1'b0;
    #1 check_reset_values("async_reset");
    chk("async_reset_queue", exp_q.size(), 0);
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    repeat (15) @(negedge clk);
    chk("post_reset_idle", int'(current_state), 0);
    $display("async reset: asserted in AM_WAIT");
    run(int'($urandom_range(0, 9)), -1, 0);

    // Randomized runs, including out-of-range classes and aborts.
    for (int k = 0; k < 12; k++) begin
      am_res = int'($urandom_range(0, 15));
      drop   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, NL - 1)) : -1;
      run(am_res, drop, 0);
      if (drop < 0) chk("random_result", int'(result), am_res);
      else chk("random_abort_result", int'(result), 10);
    end

    chk("final_queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
